mem_responder: RTL and testbench
================================

# mem_responder

Bus responder for the FSM CPU's memory port: it serves instruction fetches, loads and byte-masked stores from a word-organised RAM, and decodes a small memory-mapped I/O page. The I/O page holds an LED register and an 8N1 UART transmitter. It sits at the top level directly opposite the CPU, driving `mem_rdata` and consuming `mem_addr`, `mem_wdata`, `mem_rstrb` and `mem_wstrb`.

## Interface

- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `INIT_FILE`, "": hex image loaded into RAM at elaboration; empty means no preload.
- `IO_BIT`, 22: address bit that selects the I/O page (1) over RAM (0).
- `CLK_HZ`, 12000000: clock frequency.
- `BAUD`, 115200: UART bit rate; `CLKS_PER_BIT = CLK_HZ / BAUD` (integer, truncated).

Ports:

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_addr`  in  32  byte address from the CPU.
- `mem_wdata`  in  32  store data, already lane-replicated by the CPU.
- `mem_rstrb`  in  1  read request.
- `mem_wstrb`  in  4  byte-lane write enables; nonzero means a write.
- `mem_rdata`  out  32  registered read data.
- `leds`  out  8  LED register.
- `uart_tx`  out  1  serial line; idles high.

## Operation

- RAM index is `mem_addr[log2(MEM_WORDS)+1:2]`. Upper bits other than `IO_BIT` are ignored, so addresses alias and wrap modulo RAM size. `mem_addr[1:0]` is ignored because lane selection comes only from `mem_wstrb`.
- RAM write: for each lane i with `mem_wstrb[i]=1` and `mem_addr[IO_BIT]=0`, byte i of the word is replaced by `mem_wdata[8i+7:8i]`. Lanes with a 0 strobe are untouched.
- Read: on a cycle with `mem_rstrb=1`, `mem_rdata` takes the selected word or I/O register. On cycles without `mem_rstrb`, `mem_rdata` holds its value.
- Simultaneous read and write to the same RAM word returns the old contents (read-before-write).
- I/O page register offsets are `mem_addr[4:2]`:
  - 0 LEDS: RW. `leds <= mem_wdata[7:0]` when `mem_wstrb[0]`. Reads return `{24'b0, leds}`.
  - 1 UART_DATA: write-only. A write with `mem_wstrb[0]` while idle loads `mem_wdata[7:0]` and starts transmission. A write while busy is dropped and sets `overrun`. Reads return 0.
  - 2 UART_STATUS: reads return `{30'b0, overrun, busy}`. Any write clears `overrun`.
  - 3–7: reads return 0; writes are ignored.
- UART FSM states: IDLE → START → DATA → STOP → IDLE.
  - START, each of the 8 DATA bits (LSB first), and STOP each last exactly `CLKS_PER_BIT` cycles.
  - `uart_tx` is 0 in START, the shift-register LSB in DATA, and 1 in STOP and IDLE.
  - `busy` = state ≠ IDLE. The cycle after a STOP completes, `busy` is 0 and a new write is accepted.
- Reset values:
  - `mem_rdata` = 0, `leds` = 0, `uart_tx` = 1.
  - FSM goes to IDLE, `busy` = 0, `overrun` = 0, baud and bit counters = 0.
  - RAM contents are not cleared.
  - Reset asserted mid-frame aborts the frame: `uart_tx` is 1 on the cycle after the reset edge.

## Timing

- Read latency is 1 cycle: `mem_rstrb` sampled at edge N gives `mem_rdata` valid after edge N. This matches the CPU latching instruction or load data one state after asserting the strobe.
- Writes take effect at the edge where `mem_wstrb` is sampled. A read issued on the following cycle returns the new data.
- UART transmission:
  - `uart_tx` falls at the edge after the accepting write.
  - A full frame takes `10*CLKS_PER_BIT` cycles.
  - `busy` is set at the same edge as the accepting write.
- No back-pressure: every request completes in fixed time, and there is no wait or ready signal.

## Structure

- Shared package `mem_map_pkg` holds:
  - `IO_BIT`
  - register offsets `IO_LEDS=0`, `IO_UART_DATA=1`, `IO_UART_STATUS=2`
  - UART state encoding `UTX_IDLE/START/DATA/STOP`
- Sub-module `uart_tx`:
  - inputs: `clk`, `rst`, `start`, `data[7:0]`
  - outputs: `tx`, `busy`
  - parameter: `CLKS_PER_BIT`
- The top instantiates `uart_tx` and contains the RAM array, address decode and read mux.

## Test plan

- Word write then read: write `0xDEADBEEF` to addr `0x10` with strobe `1111`, then read → `mem_rdata=0xDEADBEEF` one cycle after `rstrb`.
- Byte and halfword lanes:
  - Preload `0x11223344` at `0x20`.
  - Write strobe `0100` with wdata `0xAAAAAAAA` → read `0x11AA3344`.
  - Then write strobe `0011` with wdata `0x5555BBCC` → read `0x11AABBCC`.
- Wrap and read-before-write:
  - With `MEM_WORDS=1024`, write at `0x1000` → the value reads back at `0x0000`.
  - Same-cycle read and write at one word → old value returned, new value on the next read.
- LED register: write `0x000001A5` to `IO_BIT|0x0` → `leds=0xA5`, and a read returns `0x000000A5`. Asserting `rst` → `leds=0x00` and `mem_rdata=0`.
- UART frame (with `CLKS_PER_BIT=4`):
  - Write `0x55` to UART_DATA → `uart_tx` sequence 0,1,0,1,0,1,0,1,0,1, each level for 4 cycles.
  - Status reads 1 during the frame and 0 after 40 cycles.
- UART overrun and reset:
  - Second write during a frame → frame unchanged, status = `0b11`.
  - Write to STATUS → `0b01`.
  - `rst` mid-frame → `uart_tx=1` and status = 0 the next cycle.

Source files
------------

// File: rtl/mem_map_pkg.sv
// mem_map_pkg
// Shared memory-map constants for the CPU memory responder: the address bit
// that selects the I/O page, the I/O register offsets (word offsets taken
// from mem_addr[4:2]) and the UART transmitter state encoding.
package mem_map_pkg;

    localparam int IO_BIT = 22;

    localparam logic [2:0] IO_LEDS        = 3'd0;
    localparam logic [2:0] IO_UART_DATA   = 3'd1;
    localparam logic [2:0] IO_UART_STATUS = 3'd2;

    typedef enum logic [1:0] {
        UTX_IDLE  = 2'd0,
        UTX_START = 2'd1,
        UTX_DATA  = 2'd2,
        UTX_STOP  = 2'd3
    } utx_state_e;

endpackage

// File: rtl/uart_tx.sv
// uart_tx
// 8N1 serial transmitter. A start pulse while idle latches data and sends
// start bit, 8 data bits LSB first and a stop bit, each CLKS_PER_BIT cycles.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset (aborts any frame)
//   start  in   begin a frame; ignored while busy
//   data   in   byte to send, sampled with start
//   tx     out  serial line, idles high (registered)
//   busy   out  high whenever a frame is in progress
//
// state     | meaning
// UTX_IDLE  | line high, waiting for start
// UTX_START | driving the start bit (0)
// UTX_DATA  | driving shreg_q[0], 8 bits
// UTX_STOP  | driving the stop bit (1)
module uart_tx
    import mem_map_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LOAD = CW'(CLKS_PER_BIT - 1);

    utx_state_e    state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UTX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    // Baud timer is a down-counter: each bit period ends when it reaches 0.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            UTX_IDLE: begin
                if (start) begin
                    state_d = UTX_START;
                    baud_d  = BAUD_LOAD;
                    shreg_d = data;
                end
            end
            UTX_START: begin
                if (baud_q == '0) begin
                    state_d = UTX_DATA;
                    baud_d  = BAUD_LOAD;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            UTX_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = UTX_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            UTX_STOP: begin
                if (baud_q == '0) begin
                    state_d = UTX_IDLE;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = UTX_IDLE;
        endcase
    end

    // Line level is registered from the next state so tx is glitch-free and
    // changes on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            UTX_START: tx_d = 1'b0;
            UTX_DATA:  tx_d = shreg_d[0];
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != UTX_IDLE);

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory-port responder for the FSM CPU: word RAM with byte-lane writes and
// a small I/O page (LED register, UART transmitter) selected by IO_BIT.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset (RAM is not cleared)
//   mem_addr   in   byte address
//   mem_wdata  in   store data, lane-replicated
//   mem_rstrb  in   read request; mem_rdata updates one edge later
//   mem_wstrb  in   byte-lane write enables
//   mem_rdata  out  registered read data, holds between reads
//   leds       out  LED register
//   uart_tx    out  serial line, idles high
module mem_responder #(
    parameter int    MEM_WORDS = 1024,
    parameter string INIT_FILE = "",
    parameter int    IO_BIT    = 22,
    parameter int    CLK_HZ    = 12000000,
    parameter int    BAUD      = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_rstrb,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    import mem_map_pkg::*;

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int AW           = $clog2(MEM_WORDS);

    logic [31:0]   ram_q [MEM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          io_sel;
    logic [2:0]    io_off;
    logic          io_data_wr;
    logic          tx_start, tx_busy, tx_line;
    logic [31:0]   rdata_q, rdata_d;
    logic [7:0]    leds_q, leds_d;
    logic          overrun_q, overrun_d;
    logic          unused_ok;

    // Address bits outside the index/offset/IO_BIT fields are don't-care.
    assign unused_ok  = ^{mem_addr, mem_wdata};

    assign ram_idx    = mem_addr[AW+1:2];
    assign io_sel     = mem_addr[IO_BIT];
    assign io_off     = mem_addr[4:2];
    assign io_data_wr = io_sel && (io_off == IO_UART_DATA) && mem_wstrb[0];
    assign tx_start   = io_data_wr && !tx_busy;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!io_sel && mem_wstrb[i]) begin
                ram_q[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // RAM is read from the pre-edge array, so a same-cycle write to the
    // same word returns the old contents.
    always_comb begin
        rdata_d = ram_q[ram_idx];
        if (io_sel) begin
            case (io_off)
                IO_LEDS:        rdata_d = {24'b0, leds_q};
                IO_UART_STATUS: rdata_d = {30'b0, overrun_q, tx_busy};
                default:        rdata_d = 32'b0;
            endcase
        end
    end

    always_comb begin
        leds_d    = leds_q;
        overrun_d = overrun_q;
        if (io_sel && (io_off == IO_LEDS) && mem_wstrb[0]) begin
            leds_d = mem_wdata[7:0];
        end
        if (io_data_wr && tx_busy) begin
            overrun_d = 1'b1;
        end else if (io_sel && (io_off == IO_UART_STATUS) && (mem_wstrb != 4'b0)) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q   <= '0;
            leds_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (mem_rstrb) begin
                rdata_q <= rdata_d;
            end
            leds_q    <= leds_d;
            overrun_q <= overrun_d;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk  (clk),
        .rst  (rst),
        .start(tx_start),
        .data (mem_wdata[7:0]),
        .tx   (tx_line),
        .busy (tx_busy)
    );

    assign mem_rdata = rdata_q;
    assign leds      = leds_q;
    assign uart_tx   = tx_line;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int          CPB      = 4;
    localparam logic [31:0] IO_BASE  = 32'h0040_0000;
    localparam logic [31:0] A_LEDS   = IO_BASE | 32'h0;
    localparam logic [31:0] A_DATA   = IO_BASE | 32'h4;
    localparam logic [31:0] A_STATUS = IO_BASE | 32'h8;
    localparam logic [31:0] A_UNMAP  = IO_BASE | 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rstrb;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic [7:0]  leds;
    logic        uart_tx;

    int n_cmp = 0;
    int n_err = 0;

    mem_responder #(
        .MEM_WORDS(1024),
        .INIT_FILE(""),
        .IO_BIT   (22),
        .CLK_HZ   (400),
        .BAUD     (100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rstrb(mem_rstrb),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .leds     (leds),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    // Expected line level k cycles after the accepting edge of an 8N1 frame.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int j;
        j = k / CPB;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_rstrb = 1'b0;
        @(posedge clk);
        #1;
        mem_wstrb = 4'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        mem_wstrb = 4'b0;
        @(posedge clk);
        #1;
        d = mem_rdata;
        mem_rstrb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_addr = '0; mem_wdata = '0; mem_rstrb = 1'b0; mem_wstrb = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        if (mem_rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h expected %h", mem_rdata, 32'h0); n_err++; end
        n_cmp++;
        if (leds !== 8'h00) begin $display("FAIL reset_leds: got %h expected %h", leds, 8'h00); n_err++; end
        n_cmp++;
        if (uart_tx !== 1'b1) begin $display("FAIL reset_tx: got %b expected 1", uart_tx); n_err++; end
        n_cmp++;
        rst = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] d;
        do_write(32'h10, 32'hDEADBEEF, 4'b1111);
        do_read(32'h10, d);
        if (d !== 32'hDEADBEEF) begin $display("FAIL word_rw: got %h expected %h", d, 32'hDEADBEEF); n_err++; end
        n_cmp++;
    endtask

    task automatic test_lanes();
        logic [31:0] d;
        do_write(32'h20, 32'h11223344, 4'b1111);
        do_write(32'h20, 32'hAAAAAAAA, 4'b0100);
        do_read(32'h20, d);
        if (d !== 32'h11AA3344) begin $display("FAIL lane_byte2: got %h expected %h", d, 32'h11AA3344); n_err++; end
        n_cmp++;
        do_write(32'h20, 32'h5555BBCC, 4'b0011);
        do_read(32'h20, d);
        if (d !== 32'h11AABBCC) begin $display("FAIL lane_half0: got %h expected %h", d, 32'h11AABBCC); n_err++; end
        n_cmp++;
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        do_write(32'h1000, 32'hCAFEF00D, 4'b1111);
        do_read(32'h0000, d);
        if (d !== 32'hCAFEF00D) begin $display("FAIL wrap: got %h expected %h", d, 32'hCAFEF00D); n_err++; end
        n_cmp++;
    endtask

    task automatic test_rbw();
        logic [31:0] d;
        do_write(32'h30, 32'h12345678, 4'b1111);
        mem_addr  = 32'h30;
        mem_wdata = 32'h87654321;
        mem_wstrb = 4'b1111;
        mem_rstrb = 1'b1;
        @(posedge clk);
        #1;
        mem_wstrb = 4'b0;
        mem_rstrb = 1'b0;
        if (mem_rdata !== 32'h12345678) begin $display("FAIL rbw_old: got %h expected %h", mem_rdata, 32'h12345678); n_err++; end
        n_cmp++;
        do_read(32'h30, d);
        if (d !== 32'h87654321) begin $display("FAIL rbw_new: got %h expected %h", d, 32'h87654321); n_err++; end
        n_cmp++;
    endtask

    task automatic test_hold();
        logic [31:0] d;
        do_read(32'h10, d);
        mem_addr = 32'h20;
        @(posedge clk);
        #1;
        if (mem_rdata !== 32'hDEADBEEF) begin $display("FAIL rdata_hold: got %h expected %h", mem_rdata, 32'hDEADBEEF); n_err++; end
        n_cmp++;
    endtask

    task automatic test_leds();
        logic [31:0] d;
        do_write(A_LEDS, 32'h000001A5, 4'b1111);
        if (leds !== 8'hA5) begin $display("FAIL leds_out: got %h expected %h", leds, 8'hA5); n_err++; end
        n_cmp++;
        do_read(A_LEDS, d);
        if (d !== 32'h000000A5) begin $display("FAIL leds_read: got %h expected %h", d, 32'h000000A5); n_err++; end
        n_cmp++;
        do_read(32'h0000, d);
        if (d !== 32'hCAFEF00D) begin $display("FAIL io_no_ram: got %h expected %h", d, 32'hCAFEF00D); n_err++; end
        n_cmp++;
        do_read(A_LEDS, d);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (leds !== 8'h00) begin $display("FAIL leds_rst: got %h expected %h", leds, 8'h00); n_err++; end
        n_cmp++;
        if (mem_rdata !== 32'h0) begin $display("FAIL rdata_rst: got %h expected %h", mem_rdata, 32'h0); n_err++; end
        n_cmp++;
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        do_write(A_UNMAP, 32'hFFFFFFFF, 4'b1111);
        do_read(A_UNMAP, d);
        if (d !== 32'h0) begin $display("FAIL unmapped_read: got %h expected %h", d, 32'h0); n_err++; end
        n_cmp++;
        do_read(A_DATA, d);
        if (d !== 32'h0) begin $display("FAIL uart_data_read: got %h expected %h", d, 32'h0); n_err++; end
        n_cmp++;
        if (uart_tx !== 1'b1) begin $display("FAIL tx_idle: got %b expected 1", uart_tx); n_err++; end
        n_cmp++;
    endtask

    task automatic test_uart_frame();
        logic [31:0] d;
        do_write(A_DATA, 32'h00000055, 4'b0001);
        mem_addr  = A_STATUS;
        mem_rstrb = 1'b1;
        for (int k = 0; k < 10*CPB; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                if (mem_rdata !== 32'h1) begin $display("FAIL frame_status k=%0d: got %h expected %h", k, mem_rdata, 32'h1); n_err++; end
                n_cmp++;
            end
            if (uart_tx !== frame_bit(8'h55, k)) begin
                $display("FAIL frame_tx k=%0d: got %b expected %b", k, uart_tx, frame_bit(8'h55, k)); n_err++;
            end
            n_cmp++;
        end
        @(posedge clk);
        #1;
        if (uart_tx !== 1'b1) begin $display("FAIL frame_end_tx: got %b expected 1", uart_tx); n_err++; end
        n_cmp++;
        if (mem_rdata !== 32'h1) begin $display("FAIL frame_last_busy: got %h expected %h", mem_rdata, 32'h1); n_err++; end
        n_cmp++;
        mem_rstrb = 1'b0;
        // Next frame accepted on the first idle cycle.
        do_write(A_DATA, 32'h0000000F, 4'b0001);
        if (uart_tx !== 1'b0) begin $display("FAIL b2b_start: got %b expected 0", uart_tx); n_err++; end
        n_cmp++;
        do_read(A_STATUS, d);
        if (d !== 32'h1) begin $display("FAIL b2b_status: got %h expected %h", d, 32'h1); n_err++; end
        n_cmp++;
        repeat (39) @(posedge clk);
        #1;
        do_read(A_STATUS, d);
        if (d !== 32'h0) begin $display("FAIL frame_done_status: got %h expected %h", d, 32'h0); n_err++; end
        n_cmp++;
    endtask

    task automatic test_overrun();
        do_write(A_DATA, 32'h000000A3, 4'b0001);
        for (int k = 0; k < 10*CPB; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (uart_tx !== frame_bit(8'hA3, k)) begin
                $display("FAIL ovr_tx k=%0d: got %b expected %b", k, uart_tx, frame_bit(8'hA3, k)); n_err++;
            end
            n_cmp++;
            if (k == 11) begin
                if (mem_rdata !== 32'h3) begin $display("FAIL ovr_status: got %h expected %h", mem_rdata, 32'h3); n_err++; end
                n_cmp++;
            end
            if (k == 17) begin
                if (mem_rdata !== 32'h1) begin $display("FAIL ovr_clear: got %h expected %h", mem_rdata, 32'h1); n_err++; end
                n_cmp++;
            end
            mem_rstrb = 1'b0;
            mem_wstrb = 4'b0;
            case (k)
                5:  begin mem_addr = A_DATA;   mem_wdata = 32'hFF; mem_wstrb = 4'b0001; end
                10: begin mem_addr = A_STATUS; mem_rstrb = 1'b1; end
                15: begin mem_addr = A_STATUS; mem_wdata = 32'h0;  mem_wstrb = 4'b1111; end
                16: begin mem_addr = A_STATUS; mem_rstrb = 1'b1; end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        do_write(A_DATA, 32'h00000000, 4'b0001);
        repeat (10) @(posedge clk);
        #1;
        if (uart_tx !== 1'b0) begin $display("FAIL midframe_low: got %b expected 0", uart_tx); n_err++; end
        n_cmp++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (uart_tx !== 1'b1) begin $display("FAIL abort_tx: got %b expected 1", uart_tx); n_err++; end
        n_cmp++;
        do_read(A_STATUS, d);
        if (d !== 32'h0) begin $display("FAIL abort_status: got %h expected %h", d, 32'h0); n_err++; end
        n_cmp++;
        if (uart_tx !== 1'b1) begin $display("FAIL abort_stays_idle: got %b expected 1", uart_tx); n_err++; end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_wrap();
        test_rbw();
        test_hold();
        test_leds();
        test_unmapped();
        test_uart_frame();
        test_overrun();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
